// File: rtl/clock_div_sequencer.sv
// Programmable clock divider with a handshaked divisor that takes effect only at
// period boundaries. Define CLOCK_DIV_SEQUENCER_PERIOD_CHECK_EN for the simulation-only phase checker.
module clock_div_sequencer #(
  parameter int WIDTH     = 8,
  parameter int RESET_DIV = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             div_valid,
  input  logic [WIDTH-1:0] div_bits,
  output logic             div_ready,
  output logic             clock_d,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    RUN_HIGH,
    RUN_LOW
  } stateT;

  stateT            state, stateNext;
  logic [WIDTH-1:0] activeDiv, activeNext;
  logic [WIDTH-1:0] pendDiv, pendDivNext;
  logic             pendValid, pendValidNext;
  logic [WIDTH-1:0] phase, phaseNext;
  logic [WIDTH-1:0] effDiv, highCount, lowCount, loadDiv;
  logic             handshake, lastHigh, lastLow, clockDNext;

  assign div_ready = ~pendValid;
  assign busy      = (state != IDLE);
  assign handshake = div_valid & div_ready;

  // A divisor of 1 cannot make a high and a low phase, so it runs as 2.
  assign effDiv    = (activeDiv == WIDTH'(1)) ? WIDTH'(2) : activeDiv;
  assign highCount = effDiv >> 1;
  assign lowCount  = effDiv - highCount;
  assign lastHigh  = (phase == highCount - WIDTH'(1));
  assign lastLow   = (phase == lowCount - WIDTH'(1));

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    stateNext     = state;
    phaseNext     = phase;
    activeNext    = activeDiv;
    pendDivNext   = pendDiv;
    pendValidNext = pendValid;
    loadDiv       = activeDiv;

    case (state)
      IDLE: begin
        if (handshake) loadDiv = div_bits;
        activeNext = loadDiv;
        if (enable && (loadDiv != '0)) begin
          stateNext = RUN_HIGH;
          phaseNext = '0;
        end
      end

      RUN_HIGH: begin
        if (handshake) begin
          pendValidNext = 1'b1;
          pendDivNext   = div_bits;
        end
        if (lastHigh) begin
          stateNext = RUN_LOW;
          phaseNext = '0;
        end else begin
          phaseNext = phase + WIDTH'(1);
        end
      end

      RUN_LOW: begin
        if (handshake) begin
          pendValidNext = 1'b1;
          pendDivNext   = div_bits;
        end
        if (lastLow) begin
          // Period boundary: promote the pending divisor before deciding to stop.
          if (pendValid) begin
            loadDiv       = pendDiv;
            pendValidNext = 1'b0;
          end
          activeNext = loadDiv;
          phaseNext  = '0;
          stateNext  = (enable && (loadDiv != '0)) ? RUN_HIGH : IDLE;
        end else begin
          phaseNext = phase + WIDTH'(1);
        end
      end

      default: stateNext = IDLE;
    endcase

    clockDNext = (stateNext == RUN_HIGH);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      phase     <= '0;
      activeDiv <= WIDTH'(RESET_DIV);
      pendDiv   <= '0;
      pendValid <= 1'b0;
      clock_d   <= 1'b0;
    end else begin
      state     <= stateNext;
      phase     <= phaseNext;
      activeDiv <= activeNext;
      pendDiv   <= pendDivNext;
      pendValid <= pendValidNext;
      clock_d   <= clockDNext;
    end
  end

`ifdef CLOCK_DIV_SEQUENCER_PERIOD_CHECK_EN
  // Measures each completed high run of clock_d and each completed running low run.
  int unsigned highRun, lowRun;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      highRun <= 0;
      lowRun  <= 0;
    end else if (clock_d) begin
      if (!clockDNext) begin
        if (highRun + 1 != int'(highCount))
          $fatal(1, "clock_d high run %0d, expected %0d", highRun + 1, highCount);
        highRun <= 0;
        lowRun  <= 0;
      end else begin
        highRun <= highRun + 1;
      end
    end else if (state == RUN_LOW) begin
      if (stateNext != RUN_LOW) begin
        if (lowRun + 1 != int'(lowCount))
          $fatal(1, "clock_d low run %0d, expected %0d", lowRun + 1, lowCount);
        lowRun <= 0;
      end else begin
        lowRun <= lowRun + 1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_clock_div_sequencer.sv
// Self-checking bench for clock_div_sequencer: directed scenarios with literal
// expectations plus randomized traffic compared each cycle against a period model.
module tb_clock_div_sequencer;

  localparam int WIDTH     = 8;
  localparam int RESET_DIV = 2;

  logic             clock = 1'b0;
  logic             reset;
  logic             enable;
  logic             div_valid;
  logic [WIDTH-1:0] div_bits;
  logic             div_ready;
  logic             clock_d;
  logic             busy;

  clock_div_sequencer #(.WIDTH(WIDTH), .RESET_DIV(RESET_DIV)) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .div_valid (div_valid),
    .div_bits  (div_bits),
    .div_ready (div_ready),
    .clock_d   (clock_d),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  int          nChecks = 0;
  int          nFail   = 0;
  logic [31:0] trace;

  // Model: a running flag and a position within the current period.
  bit mRunning, mPendValid;
  int mPos, mAct, mPendDiv;
  bit mClk, mBusy, mReady;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic int effOf(input int d);
    return (d == 1) ? 2 : d;
  endfunction

  task automatic modelOutputs();
    mClk   = mRunning && (mPos < effOf(mAct) / 2);
    mBusy  = mRunning;
    mReady = !mPendValid;
  endtask

  task automatic modelReset();
    mRunning   = 0;
    mPos       = 0;
    mAct       = RESET_DIV;
    mPendValid = 0;
    mPendDiv   = 0;
    modelOutputs();
  endtask

  task automatic modelStep();
    bit hs;
    int bits;
    hs   = div_valid && !mPendValid;
    bits = int'(div_bits);
    if (!mRunning) begin
      if (hs) mAct = bits;
      if (enable && mAct != 0) begin
        mRunning = 1;
        mPos     = 0;
      end
    end else if (mPos == effOf(mAct) - 1) begin
      if (mPendValid) begin
        mAct       = mPendDiv;
        mPendValid = 0;
      end else if (hs) begin
        mPendValid = 1;
        mPendDiv   = bits;
      end
      if (enable && mAct != 0) mPos = 0;
      else mRunning = 0;
    end else begin
      mPos++;
      if (hs) begin
        mPendValid = 1;
        mPendDiv   = bits;
      end
    end
    modelOutputs();
  endtask

  // Continuous comparison against the model, mid-cycle.
  always @(negedge clock) begin
    check("clock_d", clock_d, mClk);
    check("busy", busy, mBusy);
    check("div_ready", div_ready, mReady);
  end

  task automatic cycle();
    @(posedge clock);
    if (reset) modelReset();
    else modelStep();
    #1;
    trace = {trace[30:0], clock_d};
  endtask

  // Bring the DUT to IDLE, load a divisor directly, then enable for one cycle.
  task automatic startWith(input int d);
    int n;
    n         = 0;
    enable    = 1'b0;
    div_valid = 1'b0;
    while (busy && n < 600) begin
      cycle();
      n++;
    end
    check("idle_wait", busy, 0);
    div_valid = 1'b1;
    div_bits  = WIDTH'(d);
    cycle();
    div_valid = 1'b0;
    enable    = 1'b1;
    cycle();
  endtask

  initial begin
    reset     = 1'b1;
    enable    = 1'b0;
    div_valid = 1'b0;
    div_bits  = '0;
    trace     = '0;
    modelReset();
    #1;
    check("reset_clock_d", clock_d, 0);
    check("reset_busy", busy, 0);
    check("reset_ready", div_ready, 1);
    repeat (2) cycle();
    reset = 1'b0;

    // Divisor 6: 3 high / 3 low, high one cycle after enable.
    startWith(6);
    check("div6_first_high", clock_d, 1);
    check("div6_busy", busy, 1);
    repeat (11) cycle();
    check("div6_pattern", trace[11:0], 12'b111000111000);

    // Divisor 5: 2 high / 3 low.
    startWith(5);
    repeat (9) cycle();
    check("div5_pattern", trace[9:0], 10'b1100011000);

    // Divisor 1 runs as 2.
    startWith(1);
    repeat (3) cycle();
    check("div1_pattern", trace[3:0], 4'b1010);

    // Divisor 4 running, offer 8 during the high phase.
    startWith(4);
    div_valid = 1'b1;
    div_bits  = WIDTH'(8);
    cycle();
    div_valid = 1'b0;
    check("pend_ready_low", div_ready, 0);
    repeat (2) cycle();
    check("pend_ready_boundary", div_ready, 0);
    cycle();
    check("pend_ready_after", div_ready, 1);
    repeat (7) cycle();
    check("div4_to_8_pattern", trace[11:0], 12'b110011110000);

    // Enable dropped on the 2nd high cycle: period completes, then IDLE.
    startWith(6);
    cycle();
    enable = 1'b0;
    repeat (4) cycle();
    check("stop_last_low_busy", busy, 1);
    cycle();
    check("stop_pattern", trace[6:0], 7'b1110000);
    check("stop_busy", busy, 0);
    check("stop_clock_d", clock_d, 0);

    // Divisor 0 written while running stops at the boundary and stays stopped.
    startWith(6);
    div_valid = 1'b1;
    div_bits  = '0;
    cycle();
    div_valid = 1'b0;
    repeat (5) cycle();
    check("div0_pattern", trace[6:0], 7'b1110000);
    check("div0_busy", busy, 0);
    repeat (3) cycle();
    check("div0_stays_idle", busy, 0);

    // Reset during a high phase, then restart at RESET_DIV.
    startWith(6);
    #2;
    reset = 1'b1;
    modelReset();
    #1;
    check("async_reset_clock_d", clock_d, 0);
    check("async_reset_busy", busy, 0);
    check("async_reset_ready", div_ready, 1);
    repeat (2) cycle();
    reset = 1'b0;
    cycle();
    check("restart_high", clock_d, 1);
    repeat (3) cycle();
    check("restart_pattern", trace[3:0], 4'b1010);

    // Randomized traffic checked by the model every cycle.
    for (int i = 0; i < 4000; i++) begin
      enable    = ($urandom_range(0, 9) != 0);
      div_valid = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 7))
        0:       div_bits = '0;
        1:       div_bits = WIDTH'(1);
        7:       div_bits = WIDTH'($urandom_range(2, 40));
        default: div_bits = WIDTH'($urandom_range(2, 9));
      endcase
      if ($urandom_range(0, 599) == 0) begin
        #2;
        reset = 1'b1;
        modelReset();
        cycle();
        reset = 1'b0;
      end else begin
        cycle();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/clock_div_sequencer.md
CLOCK_DIV_SEQUENCER -- requirements
Module: clock_div_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bit width of the divisor.
REQ-002 SHALL have parameter RESET_DIV, default 2, active divisor loaded at reset (legal range 2..2^WIDTH-1).
REQ-003 SHALL have port clock  input  1  the only clock; all state is on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port enable  input  1  request to run the divided clock.
REQ-006 SHALL have port div_valid  input  1  a new divisor is offered.
REQ-007 SHALL have port div_bits  input  WIDTH  offered divisor (period in clock cycles).
REQ-008 SHALL have port div_ready  output  1  sequencer can accept a divisor.
REQ-009 SHALL have port clock_d  output  1  registered divided-clock level; drives the d input of the downstream clock flop.
REQ-010 SHALL have port busy  output  1  high while in RUN_HIGH or RUN_LOW.

Function
REQ-011 SHALL implement states IDLE, RUN_HIGH and RUN_LOW, plus a phase counter and a one-entry pending-divisor register.
REQ-012 SHALL clamp an effective divisor of 1 to 2; divisor 0 SHALL mean stop.
REQ-013 For active divisor N >= 2, SHALL hold clock_d high for floor(N/2) cycles, then low for N-floor(N/2) cycles, repeating.
REQ-014 IDLE->RUN_HIGH SHALL occur when enable=1 and the active divisor is nonzero; clock_d SHALL be 1 in the cycle after enable is sampled high.
REQ-015 A handshake SHALL complete when div_valid and div_ready are both 1.
REQ-016 A handshake in IDLE SHALL load the active divisor directly.
REQ-017 A handshake while running SHALL set the pending register.
REQ-018 div_ready SHALL equal the inverse of pending-valid.
REQ-019 The pending divisor SHALL become active only at the period boundary, the last RUN_LOW cycle; the next period SHALL use it.
REQ-020 Pending-valid SHALL clear at that boundary, so div_ready is 1 in the following cycle.
REQ-021 When enable=0 or the active divisor is 0 at a period boundary, SHALL go to IDLE with clock_d=0; the current period SHALL always complete, with no runt high or low phase.
REQ-022 A pending divisor at the same boundary as an enable drop SHALL still be loaded as active before entering IDLE.
REQ-023 If enable is reasserted at the boundary itself, SHALL go directly to RUN_HIGH with no IDLE cycle.
REQ-024 busy SHALL be 1 exactly when the state is RUN_HIGH or RUN_LOW.

Reset
REQ-025 On reset assertion, SHALL immediately set state=IDLE, clock_d=0, busy=0, pending-valid=0, div_ready=1, active divisor=RESET_DIV, phase counter=0, independent of clock.
REQ-026 Reset mid-phase SHALL abandon the period; after release, operation SHALL restart per REQ-014.

Configuration
REQ-027 With CLOCK_DIV_SEQUENCER_PERIOD_CHECK_EN defined (simulation only), SHALL include a checker measuring each completed high and low run of clock_d against REQ-013 and calling $fatal on mismatch.
REQ-028 Without CLOCK_DIV_SEQUENCER_PERIOD_CHECK_EN, SHALL omit the checker; port behaviour SHALL be identical in both builds.

Verification
REQ-029 Bench SHALL cover: reset, write div 6 in IDLE, enable=1 -> clock_d 1 one cycle later; 3 high / 3 low repeating; busy=1.
REQ-030 Bench SHALL cover: div 5 -> 2 high / 3 low; div 1 -> 1 high / 1 low (clamped to 2).
REQ-031 Bench SHALL cover: running div 4, write div 8 during high phase -> div_ready 0 from next cycle, current period 2/2, then 4/4, div_ready 1 the cycle after the boundary.
REQ-032 Bench SHALL cover: div 6, drop enable on 2nd high cycle -> period completes 3 high / 3 low, then IDLE, clock_d 0, busy 0; write div 0 while running -> same stop at boundary.
REQ-033 Bench SHALL cover: assert reset during a high phase -> clock_d 0 with no clock edge; after release with enable=1 -> restart at RESET_DIV=2, 1 high / 1 low.
REQ-034 Bench SHALL cover: build with CLOCK_DIV_SEQUENCER_PERIOD_CHECK_EN, run all above -> no $fatal.
